// File: rtl/shift_pkg.sv
// Shared shifter types and constants; also used by the ALU decode.
package shift_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      SHIFT_OP_SLL  = 2'b00,
      SHIFT_OP_SRL  = 2'b01,
      SHIFT_OP_SRA  = 2'b10,
      SHIFT_OP_PASS = 2'b11
   } shift_op_e;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [SHAMT_W-1:0] shamt;
      shift_op_e          op;
   } shift_req_t;

   function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
      return {<<{x}};
   endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 5-stage logarithmic shifter; left shifts reuse the right-shift
// path by reversing the operand before and the result after.
module shift_core
   import shift_pkg::*;
(
   input  logic [DATA_W-1:0]  data,
   input  logic [SHAMT_W-1:0] shamt,
   input  shift_op_e          op,
   output logic [DATA_W-1:0]  result_c
);

   localparam logic [DATA_W-1:0] ONES = '1;

   logic [DATA_W-1:0] fill;
   logic [DATA_W-1:0] acc;

   always_comb begin
      fill = (op == SHIFT_OP_SRA) ? {DATA_W{data[DATA_W-1]}} : '0;
      acc  = (op == SHIFT_OP_SLL) ? bit_rev(data) : data;
      // stages by 16, 8, 4, 2, 1; vacated MSBs take the fill pattern
      for (int s = int'(SHAMT_W) - 1; s >= 0; s--) begin
         if (shamt[s]) begin
            acc = (acc >> (1 << s)) | (fill & ~(ONES >> (1 << s)));
         end
      end
      case (op)
         SHIFT_OP_SLL:  result_c = bit_rev(acc);
         SHIFT_OP_PASS: result_c = data;
         default:       result_c = acc;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared barrel shifter with a one-entry
// result register. Define SHIFT_ARB_PERF_EN to enable the grant counters.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned SHAMT_W   = 5,
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [2*DATA_W-1:0]    req_data,
   input  logic [2*SHAMT_W-1:0]   req_shamt,
   input  logic [3:0]             req_op,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_data,
   output logic                   rsp_id,
   output logic [CNT_W-1:0]       grant_cnt0,
   output logic [CNT_W-1:0]       grant_cnt1
);

   arb_state_e        state;
   logic              ptr;
   logic              can_accept;
   logic [NUM_REQ-1:0] gnt;
   logic              gnt_any;
   logic              gnt_id;
   shift_req_t        sel;
   logic [DATA_W-1:0] shift_res_c;

   assign can_accept = (state == ARB_EMPTY) || rsp_ready;

   // Grant is gated by reset so req_ready drops as soon as reset asserts
   always_comb begin
      gnt = '0;
      if (reset_n && can_accept) begin
         if (&req_valid) begin
            gnt = ((PRIO_MODE == 1) || !ptr) ? 2'b01 : 2'b10;
         end else begin
            gnt = req_valid;
         end
      end
   end

   assign gnt_any   = |gnt;
   assign gnt_id    = gnt[1];
   assign req_ready = gnt;

   always_comb begin
      sel.data  = gnt_id ? req_data[2*DATA_W-1:DATA_W]    : req_data[DATA_W-1:0];
      sel.shamt = gnt_id ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
      sel.op    = shift_op_e'(gnt_id ? req_op[3:2] : req_op[1:0]);
   end

   shift_core u_core (
      .data     (sel.data),
      .shamt    (sel.shamt),
      .op       (sel.op),
      .result_c (shift_res_c)
   );

   // Output register FSM; a grant while FULL overwrites the result being drained
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ARB_EMPTY;
         ptr      <= 1'b0;
         rsp_data <= '0;
         rsp_id   <= 1'b0;
      end else begin
         case (state)
            ARB_EMPTY: if (gnt_any) state <= ARB_FULL;
            ARB_FULL:  if (rsp_ready && !gnt_any) state <= ARB_EMPTY;
            default:   state <= ARB_EMPTY;
         endcase
         if (gnt_any) begin
            rsp_data <= shift_res_c;
            rsp_id   <= gnt_id;
            ptr      <= ~gnt_id;
         end
      end
   end

   assign rsp_valid = (state == ARB_FULL);

`ifdef SHIFT_ARB_PERF_EN
   // Saturating per-requester grant counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (gnt[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         if (gnt[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
   end
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter against a behavioural model.
module tb_shift_arbiter;

   localparam int unsigned PRIO = 0;

   logic        clock;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_data;
   logic [9:0]  req_shamt;
   logic [3:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_id;
   logic [15:0] grant_cnt0;
   logic [15:0] grant_cnt1;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   // model state
   bit          m_full;
   logic [31:0] m_data;
   logic        m_id;
   logic        m_ptr;
   int          m_cnt0;
   int          m_cnt1;

   shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .PRIO_MODE(PRIO)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_shamt(req_shamt), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_grant();
      if (!reset_n || (m_full && !rsp_ready)) return 2'b00;
      if (req_valid == 2'b11) return ((PRIO == 1) || !m_ptr) ? 2'b01 : 2'b10;
      return req_valid;
   endfunction

   function automatic logic [31:0] shift_ref(input logic [31:0] d, input logic [4:0] sh,
                                             input logic [1:0] op);
      case (op)
         2'b00:   return d << sh;
         2'b01:   return d >> sh;
         2'b10:   return $unsigned($signed(d) >>> sh);
         default: return d;
      endcase
   endfunction

   task automatic model_reset();
      m_full = 0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
   endtask

   // advance one clock; the model consumes the inputs seen at the edge
   task automatic cycle();
      logic [1:0] g;
      logic       id;
      @(posedge clock);
      g = exp_grant();
      if (reset_n) begin
         if (g != 2'b00) begin
            id     = g[1];
            m_data = id ? shift_ref(req_data[63:32], req_shamt[9:5], req_op[3:2])
                        : shift_ref(req_data[31:0],  req_shamt[4:0], req_op[1:0]);
            m_id   = id;
            m_ptr  = !id;
            m_full = 1;
            if (id) begin if (m_cnt1 < 65535) m_cnt1++; end
            else    begin if (m_cnt0 < 65535) m_cnt0++; end
         end else if (rsp_ready) begin
            m_full = 0;
         end
      end
      #1;
   endtask

   task automatic set_req(input logic [1:0] v,
                          input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
                          input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1);
      req_valid = v;
      req_data  = {d1, d0};
      req_shamt = {s1, s0};
      req_op    = {o1, o0};
   endtask

   // per-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en) begin
         check("req_ready", 32'(req_ready), 32'(exp_grant()));
         check("rsp_valid", 32'(rsp_valid), 32'(m_full));
         if (m_full) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", 32'(rsp_id), 32'(m_id));
         end
`ifdef SHIFT_ARB_PERF_EN
         check("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
         check("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`else
         check("grant_cnt0", 32'(grant_cnt0), 32'h0);
         check("grant_cnt1", 32'(grant_cnt1), 32'h0);
`endif
      end
   end

   logic [31:0] hold;
   logic [31:0] t2_exp [4];
   logic [4:0]  t2_sh  [4];
   logic [1:0]  t2_op  [4];

   initial begin
      reset_n = 1'b0;
      rsp_ready = 1'b0;
      set_req(2'b00, 0, 0, 0, 0, 0, 0);
      model_reset();
      cycle();
      cycle();
      // reset state, with both requests pending
      set_req(2'b11, 32'h1234_5678, 5'd3, 2'b00, 32'h9abc_def0, 5'd7, 2'b10);
      rsp_ready = 1'b1;
      #2;
      check("reset_req_ready", 32'(req_ready), 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_data", rsp_data, 32'h0);
      check("reset_rsp_id", 32'(rsp_id), 32'h0);
      check("reset_cnt0", 32'(grant_cnt0), 32'h0);
      cycle();
      reset_n = 1'b1;
      set_req(2'b00, 0, 0, 0, 0, 0, 0);
      chk_en = 1;
      cycle();

      // single req 0: 1 << 31
      set_req(2'b01, 32'h0000_0001, 5'd31, 2'b00, 32'hdead_beef, 5'd1, 2'b01);
      cycle();
      set_req(2'b00, 0, 0, 0, 0, 0, 0);
      #2;
      check("t1_valid", 32'(rsp_valid), 32'h1);
      check("t1_data", rsp_data, 32'h8000_0000);
      check("t1_id", 32'(rsp_id), 32'h0);

      // SRA vs SRL and shamt boundaries on req 1
      t2_sh[0] = 5'd4;  t2_op[0] = 2'b10; t2_exp[0] = 32'hF800_000F;
      t2_sh[1] = 5'd4;  t2_op[1] = 2'b01; t2_exp[1] = 32'h0800_000F;
      t2_sh[2] = 5'd0;  t2_op[2] = 2'b10; t2_exp[2] = 32'h8000_00F0;
      t2_sh[3] = 5'd31; t2_op[3] = 2'b10; t2_exp[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         set_req(2'b10, 32'h0, 5'd0, 2'b00, 32'h8000_00F0, t2_sh[i], t2_op[i]);
         cycle();
         #2;
         check("t2_data", rsp_data, t2_exp[i]);
         check("t2_id", 32'(rsp_id), 32'h1);
      end
      set_req(2'b00, 0, 0, 0, 0, 0, 0);
      cycle();

      // contention after reset: 0,1,0,1
      reset_n = 1'b0; model_reset();
      cycle(); cycle();
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(2'b11, $urandom, 5'($urandom), 2'($urandom), $urandom, 5'($urandom), 2'($urandom));
         #2;
         check("t3_grant", 32'(req_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
         if (i > 0) check("t3_id", 32'(rsp_id), 32'((i - 1) % 2));
         cycle();
      end
      #2;
      check("t3_id_last", 32'(rsp_id), 32'h1);

      // backpressure while FULL
      rsp_ready = 1'b0;
      hold = rsp_data;
      for (int i = 0; i < 3; i++) begin
         cycle();
         #2;
         check("t4_ready", 32'(req_ready), 32'h0);
         check("t4_hold", rsp_data, hold);
      end
      rsp_ready = 1'b1;
      #1;
      check("t4_drain_grant", 32'(req_ready), 32'h1);
      cycle();

      // asynchronous reset while FULL
      rsp_ready = 1'b0;
      cycle();
      #2;
      reset_n = 1'b0; model_reset();
      #1;
      check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
      check("t5_req_ready", 32'(req_ready), 32'h0);
      cycle(); cycle();
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      #2;
      check("t5_first_grant", 32'(req_ready), 32'h1);
      cycle();
      #2;
      check("t5_rsp_id", 32'(rsp_id), 32'h0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         set_req(2'($urandom), $urandom, 5'($urandom), 2'($urandom),
                 $urandom, 5'($urandom), 2'($urandom));
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            reset_n = 1'b0; model_reset();
         end else begin
            reset_n = 1'b1;
         end
         cycle();
      end
      reset_n = 1'b1;

      // grant counters
      reset_n = 1'b0; model_reset();
      cycle();
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      set_req(2'b01, 32'h0000_00A5, 5'd1, 2'b00, 32'h0, 5'd0, 2'b00);
`ifdef SHIFT_ARB_PERF_EN
      repeat (70000) cycle();
      #2;
      check("t6_cnt0_sat", 32'(grant_cnt0), 32'h0000_FFFF);
      check("t6_cnt1", 32'(grant_cnt1), 32'h0);
`else
      repeat (20) cycle();
      #2;
      check("t6_cnt0_off", 32'(grant_cnt0), 32'h0);
      check("t6_cnt1_off", 32'(grant_cnt1), 32'h0);
`endif
      set_req(2'b00, 0, 0, 0, 0, 0, 0);
      cycle();
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
